// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered fill level, almost-full/almost-empty
// thresholds and sticky overflow/underflow error bits.
// Build option: define SYNC_FIFO_REGOUT_EN for a registered read port; the default
// build is show-ahead (rdata presents the head word combinationally).
module sync_fifo #(
    parameter int DSIZE      = 32,
    parameter int ASIZE      = 4,
    parameter int AFULL_LVL  = (1 << ASIZE) - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty,
    output logic [ASIZE:0]   level,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;

    localparam logic [ASIZE:0]   DEPTH_L  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0]   AFULL_L  = (ASIZE+1)'(AFULL_LVL);
    localparam logic [ASIZE:0]   AEMPTY_L = (ASIZE+1)'(AEMPTY_LVL);
    localparam logic [ASIZE:0]   LVL_ZERO = '0;
    localparam logic [ASIZE:0]   LVL_ONE  = (ASIZE+1)'(1);
    localparam logic [ASIZE-1:0] PTR_ONE  = ASIZE'(1);

    // Reject nonsensical configurations at elaboration.
    if (DSIZE < 1) begin : g_bad_dsize
        $error("sync_fifo: DSIZE must be >= 1");
    end
    if (ASIZE < 2) begin : g_bad_asize
        $error("sync_fifo: ASIZE must be >= 2");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH - 1) begin : g_bad_afull
        $error("sync_fifo: AFULL_LVL must be in 1..DEPTH-1");
    end
    if (AEMPTY_LVL < 1 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_LVL must be in 1..DEPTH-1");
    end

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] rptr;

    logic             push;
    logic             pop;
    logic [ASIZE:0]   level_nxt;

    // Acceptance is judged on the registered flags, so a simultaneous push and
    // pop on a full (empty) FIFO degrades to a pop (push) only.
    assign push = winc && !wfull;
    assign pop  = rinc && !rempty;

    // Next fill level from the accepted operations of this cycle.
    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
        endcase
    end

    // Storage array; not reset, only accepted pushes write it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers, level, flags and sticky errors; flags are decoded from the next level
    // so they change on the same edge as level itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            rempty    <= 1'b1;
            wfull     <= 1'b0;
            awfull    <= 1'b0;
            arempty   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            level     <= level_nxt;
            rempty    <= (level_nxt == LVL_ZERO);
            wfull     <= (level_nxt == DEPTH_L);
            awfull    <= (level_nxt >= AFULL_L) && (level_nxt != DEPTH_L);
            arempty   <= (level_nxt != LVL_ZERO) && (level_nxt <= AEMPTY_L);
            // A new error in the same cycle as err_clr keeps the bit set.
            overflow  <= (winc && wfull)  || (overflow  && !err_clr);
            underflow <= (rinc && rempty) || (underflow && !err_clr);
        end
    end

`ifdef SYNC_FIFO_REGOUT_EN
    // Registered read port: capture the head word on the edge its pop is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (pop) begin
            rdata <= mem[rptr];
        end
    end
`else
    // Show-ahead read port: head word straight from the array, forced to zero while
    // empty so the output is stable and matches the reset value.
    assign rdata = rempty ? '0 : mem[rptr];
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: table-driven vectors plus hand sequences for sync_fifo, with a
// queue scoreboard tracking contents, fill level and sticky error bits.
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        winc;
    logic [31:0] wdata;
    logic        wfull;
    logic        awfull;
    logic        rinc;
    logic [31:0] rdata;
    logic        rempty;
    logic        arempty;
    logic [4:0]  level;
    logic        err_clr;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    logic        ovf_m = 1'b0;
    logic        unf_m = 1'b0;
    logic [31:0] rd_m  = 32'h0;

    typedef struct {
        logic        w;
        logic [31:0] d;
        logic        r;
        logic        c;
        int          lvl;
        logic        emp;
        logic        ful;
        logic        afl;
        logic        aem;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[12];

    sync_fifo #(
        .DSIZE(32),
        .ASIZE(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .winc     (winc),
        .wdata    (wdata),
        .wfull    (wfull),
        .awfull   (awfull),
        .rinc     (rinc),
        .rdata    (rdata),
        .rempty   (rempty),
        .arempty  (arempty),
        .level    (level),
        .err_clr  (err_clr),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_level"}, level, 0);
        check({nm, "_rempty"}, rempty, 1);
        check({nm, "_wfull"}, wfull, 0);
        check({nm, "_awfull"}, awfull, 0);
        check({nm, "_arempty"}, arempty, 0);
        check({nm, "_overflow"}, overflow, 0);
        check({nm, "_underflow"}, underflow, 0);
        check({nm, "_rdata"}, rdata, 0);
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        check("level", level, n);
        check("rempty", rempty, n == 0);
        check("wfull", wfull, n == 16);
        check("awfull", awfull, (n >= 15) && (n != 16));
        check("arempty", arempty, (n != 0) && (n <= 1));
        check("overflow", overflow, ovf_m);
        check("underflow", underflow, unf_m);
    endtask

    // One clock cycle of stimulus; the scoreboard is advanced with the
    // pre-edge model state, then outputs are compared 1ns after the edge.
    task automatic step(input logic w, input logic [31:0] d, input logic r, input logic c);
        int          n;
        logic        full_m;
        logic        empty_m;
        logic        aw;
        logic        ar;
        logic [31:0] popped;
        logic [31:0] rdata_pre;
        winc    = w;
        wdata   = d;
        rinc    = r;
        err_clr = c;
        #1;
        n       = q.size();
        full_m  = (n == 16);
        empty_m = (n == 0);
        aw      = w && !full_m;
        ar      = r && !empty_m;
        rdata_pre = rdata;
        @(posedge clk);
        #1;
        popped = 32'h0;
        if (ar) popped = q.pop_front();
        if (aw) q.push_back(d);
        ovf_m = (w && full_m)  || (ovf_m && !c);
        unf_m = (r && empty_m) || (unf_m && !c);
`ifdef SYNC_FIFO_REGOUT_EN
        if (ar) rd_m = popped;
        check("rdata_reg", rdata, rd_m);
`else
        if (ar) check("rdata_show", rdata_pre, popped);
`endif
        check_model();
        winc    = 1'b0;
        rinc    = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        winc    = 1'b0;
        wdata   = 32'h0;
        rinc    = 1'b0;
        err_clr = 1'b0;

        //          w  d       r  c  lvl emp ful afl aem ovf unf
        tbl[0]  = '{1, 32'hA,  0, 0, 1,  0,  0,  0,  1,  0,  0};
        tbl[1]  = '{0, 32'h0,  0, 0, 1,  0,  0,  0,  1,  0,  0};
        tbl[2]  = '{0, 32'h0,  1, 0, 0,  1,  0,  0,  0,  0,  0};
        tbl[3]  = '{0, 32'h0,  1, 0, 0,  1,  0,  0,  0,  0,  1};
        tbl[4]  = '{0, 32'h0,  0, 1, 0,  1,  0,  0,  0,  0,  0};
        tbl[5]  = '{1, 32'h5,  1, 0, 1,  0,  0,  0,  1,  0,  1};
        tbl[6]  = '{0, 32'h0,  1, 1, 0,  1,  0,  0,  0,  0,  0};
        tbl[7]  = '{1, 32'h11, 0, 0, 1,  0,  0,  0,  1,  0,  0};
        tbl[8]  = '{1, 32'h22, 0, 0, 2,  0,  0,  0,  0,  0,  0};
        tbl[9]  = '{1, 32'h33, 1, 0, 2,  0,  0,  0,  0,  0,  0};
        tbl[10] = '{0, 32'h0,  1, 0, 1,  0,  0,  0,  1,  0,  0};
        tbl[11] = '{0, 32'h0,  1, 0, 0,  1,  0,  0,  0,  0,  0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("idle");

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
            check($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            check($sformatf("tbl%0d_rempty", i), rempty, tbl[i].emp);
            check($sformatf("tbl%0d_wfull", i), wfull, tbl[i].ful);
            check($sformatf("tbl%0d_awfull", i), awfull, tbl[i].afl);
            check($sformatf("tbl%0d_arempty", i), arempty, tbl[i].aem);
            check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].ovf);
            check($sformatf("tbl%0d_underflow", i), underflow, tbl[i].unf);
        end

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 14) check("fill15_awfull", awfull, 1);
            if (i == 15) begin
                check("fill16_wfull", wfull, 1);
                check("fill16_awfull", awfull, 0);
                check("fill16_level", level, 16);
            end
        end
        step(1'b1, 32'hFF, 1'b0, 1'b0);
        check("push17_overflow", overflow, 1);
        check("push17_level", level, 16);
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("drain_rempty", rempty, 1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("ovf_cleared", overflow, 0);

        // Simultaneous push and pop at full and at empty.
        for (int i = 0; i < 16; i++) step(1'b1, 32'(i + 32), 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b1, 1'b0);
        check("full_both_level", level, 15);
        check("full_both_overflow", overflow, 1);
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h88, 1'b1, 1'b1);
        check("empty_both_level", level, 1);
        check("empty_both_underflow", underflow, 1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("errs_cleared", overflow | underflow, 0);

        // Steady streaming across pointer wraps.
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i + 200), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 32'(i + 300), 1'b1, 1'b0);
        check("stream_level", level, 8);
        step(1'b1, 32'h1234, 1'b0, 1'b0);
        check("prerst_level", level, 9);

        // Asynchronous reset in the middle of a cycle.
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 32'hDEAD;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        rd_m  = 32'h0;
        winc  = 1'b0;
        rinc  = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("midrst_held");
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Sticky underflow: set wins over a same-cycle clear, plain clear takes a cycle.
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("unf_set", underflow, 1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("unf_set_wins", underflow, 1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("unf_clear", underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
